// File: rtl/mp_pkg.sv
// Shared constants, lane-wise signed max helper and row-parity state encoding
// for the 2x2 max-pool stream stage.
package mp_pkg;

    localparam int unsigned MP_DATA_WIDTH = 32;
    localparam int unsigned MP_LANE_WIDTH = 8;
    localparam int unsigned LANES         = MP_DATA_WIDTH / MP_LANE_WIDTH;

    typedef enum logic {
        ROW_EVEN = 1'b0,
        ROW_ODD  = 1'b1
    } row_state_e;

    // Per-lane signed maximum of two packed words.
    function automatic logic [MP_DATA_WIDTH-1:0] lane_max(
        input logic [MP_DATA_WIDTH-1:0] a,
        input logic [MP_DATA_WIDTH-1:0] b
    );
        logic [MP_DATA_WIDTH-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            r[i*MP_LANE_WIDTH +: MP_LANE_WIDTH] =
                ($signed(a[i*MP_LANE_WIDTH +: MP_LANE_WIDTH]) >
                 $signed(b[i*MP_LANE_WIDTH +: MP_LANE_WIDTH]))
                ? a[i*MP_LANE_WIDTH +: MP_LANE_WIDTH]
                : b[i*MP_LANE_WIDTH +: MP_LANE_WIDTH];
        end
        return r;
    endfunction

endpackage

// File: rtl/mp_bram.sv
// Single-port block RAM, no-change write mode, optional output register.
// Contents are never reset; rsta (active-low) only clears the output register.
module mp_bram #(
    parameter int unsigned RAM_WIDTH       = 32,
    parameter int unsigned RAM_DEPTH       = 16,
    parameter string       RAM_PERFORMANCE = "LOW_LATENCY",
    localparam int unsigned ADDR_W         = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
    input  logic                 clka,
    input  logic                 rsta,
    input  logic                 ena,
    input  logic                 wea,
    input  logic                 regcea,
    input  logic [ADDR_W-1:0]    addra,
    input  logic [RAM_WIDTH-1:0] dina,
    output logic [RAM_WIDTH-1:0] douta
);

    localparam bit LOW_LAT = (RAM_PERFORMANCE == "LOW_LATENCY");

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data;
    logic [RAM_WIDTH-1:0] douta_reg;

    // Read data only updates on a read access, so it holds between accesses.
    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) begin
                mem[addra] <= dina;
            end else begin
                ram_data <= mem[addra];
            end
        end
    end

    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            douta_reg <= '0;
        end else if (regcea) begin
            douta_reg <= ram_data;
        end
    end

    assign douta = LOW_LAT ? ram_data : douta_reg;

endmodule

// File: rtl/mp_pool2x2_stream.sv
// Streaming 2x2 stride-2 max-pool: even-row pair maxima are parked in a
// half-row line buffer and combined with the odd-row pair below them.
module mp_pool2x2_stream
    import mp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MP_DATA_WIDTH,
    parameter int unsigned LANE_WIDTH = MP_LANE_WIDTH,
    parameter int unsigned IMG_W      = 26,
    parameter int unsigned IMG_H      = 26
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  frame_done
);

    localparam int unsigned COL_W  = $clog2(IMG_W);
    localparam int unsigned ROW_W  = $clog2(IMG_H);
    localparam int unsigned DEPTH  = IMG_W / 2;
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DATA_WIDTH != MP_DATA_WIDTH || LANE_WIDTH != MP_LANE_WIDTH) begin : g_bad_cfg
        $error("mp_pool2x2_stream: lane geometry must match mp_pkg");
    end

    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    row_state_e            state;
    logic [DATA_WIDTH-1:0] hold;
    logic [DATA_WIDTH-1:0] douta;
    logic [DATA_WIDTH-1:0] pair_max_c;
    logic                  accept_c;
    logic                  col_odd_c;
    logic                  col_last_c;
    logic                  row_last_c;
    logic                  bram_en_c;

    assign s_ready    = !(m_valid && !m_ready);
    assign accept_c   = s_valid && s_ready;
    assign col_odd_c  = col[0];
    assign col_last_c = (col == COL_W'(IMG_W - 1));
    assign row_last_c = (row == ROW_W'(IMG_H - 1));
    assign pair_max_c = lane_max(hold, s_data);

    // Even rows write the pair max on odd columns; odd rows prefetch on even columns.
    assign bram_en_c = accept_c &&
                       (((state == ROW_EVEN) &&  col_odd_c) ||
                        ((state == ROW_ODD)  && !col_odd_c));

    mp_bram #(
        .RAM_WIDTH      (DATA_WIDTH),
        .RAM_DEPTH      (DEPTH),
        .RAM_PERFORMANCE("LOW_LATENCY")
    ) u_line_buf (
        .clka  (clka),
        .rsta  (1'b1),
        .ena   (bram_en_c),
        .wea   (state == ROW_EVEN),
        .regcea(1'b1),
        .addra (ADDR_W'(col >> 1)),
        .dina  (pair_max_c),
        .douta (douta)
    );

    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            col        <= '0;
            row        <= '0;
            state      <= ROW_EVEN;
            hold       <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= m_valid && m_ready && m_last;
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            if (accept_c) begin
                if (!col_odd_c) begin
                    hold <= s_data;
                end
                if (col_last_c) begin
                    col   <= '0;
                    row   <= row_last_c ? '0 : row + ROW_W'(1);
                    state <= (state == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
                end else begin
                    col <= col + COL_W'(1);
                end
                // An accept implies the output register is free or draining this cycle.
                if ((state == ROW_ODD) && col_odd_c) begin
                    m_data  <= lane_max(pair_max_c, douta);
                    m_valid <= 1'b1;
                    m_last  <= row_last_c && col_last_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_mp_pool2x2_stream.sv
// Randomized bench for mp_pool2x2_stream: a 4x4 and a 26x26 instance checked
// against a per-lane max-of-four reference computed from whole frames.
module tb_mp_pool2x2_stream;

    logic        clk;
    logic        rst_n;
    logic        s_valid    [2];
    logic        s_ready    [2];
    logic [31:0] s_data     [2];
    logic        m_valid    [2];
    logic        m_ready    [2];
    logic [31:0] m_data     [2];
    logic        m_last     [2];
    logic        frame_done [2];

    logic [32:0] got [2][$];
    logic [32:0] exp [2][$];
    int          fd_cnt [2];
    int          total;
    int          bad;
    int          cyc;

    mp_pool2x2_stream #(.IMG_W(4), .IMG_H(4)) u_small (
        .clka(clk), .rsta(rst_n),
        .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]),
        .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]),
        .m_last(m_last[0]), .frame_done(frame_done[0])
    );

    mp_pool2x2_stream #(.IMG_W(26), .IMG_H(26)) u_big (
        .clka(clk), .rsta(rst_n),
        .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]),
        .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]),
        .m_last(m_last[1]), .frame_done(frame_done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Output capture, away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (m_valid[i] && m_ready[i]) got[i].push_back({m_last[i], m_data[i]});
            if (frame_done[i]) fd_cnt[i]++;
        end
    end

    function automatic logic [31:0] pool4(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
        logic [31:0] w [4];
        logic [31:0] r;
        int m;
        int v;
        w = '{a, b, c, d};
        r = '0;
        for (int k = 0; k < 4; k++) begin
            m = -1000;
            for (int j = 0; j < 4; j++) begin
                v = int'($signed(w[j][8*k +: 8]));
                if (v > m) m = v;
            end
            r[8*k +: 8] = 8'(m);
        end
        return r;
    endfunction

    task automatic send(input int sel, input logic [31:0] d, input int gap);
        int  n;
        logic acc;
        while (int'($urandom_range(99)) < gap) begin
            s_valid[sel] = 1'b0;
            @(posedge clk); #1;
        end
        s_valid[sel] = 1'b1;
        s_data[sel]  = d;
        n = 0;
        forever begin
            @(negedge clk); acc = s_ready[sel];
            @(posedge clk); #1;
            if (acc) break;
            n++;
            if (n > 300) begin
                check("accept_timeout", 64'(0), 64'(1));
                break;
            end
        end
        s_valid[sel] = 1'b0;
    endtask

    // mode 0: lane0 = raster index; mode 1: random; mode 2: signed corner block then random.
    task automatic run_frame(input int sel, input int mode, input int gap, input int nwords);
        logic [31:0] pix [26][26];
        int w;
        w = sel ? 26 : 4;
        for (int r = 0; r < w; r++) begin
            for (int c = 0; c < w; c++) begin
                pix[r][c] = (mode == 0) ? 32'(r*w + c) : $urandom;
            end
        end
        if (mode == 2) begin
            pix[0][0] = 32'h807F_FF01; pix[0][1] = 32'h0180_00FF;
            pix[1][0] = 32'hFE00_0180; pix[1][1] = 32'h7F81_8000;
        end
        for (int r = 1; r < w; r += 2) begin
            for (int c = 1; c < w; c += 2) begin
                if (r*w + c < nwords)
                    exp[sel].push_back({(r == w-1) && (c == w-1),
                        pool4(pix[r-1][c-1], pix[r-1][c], pix[r][c-1], pix[r][c])});
            end
        end
        for (int i = 0; i < nwords; i++) send(sel, pix[i / w][i % w], gap);
    endtask

    task automatic drain_and_compare(input int sel, input string tag);
        int n;
        n = 0;
        while (got[sel].size() < exp[sel].size() && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_count"}, 64'(got[sel].size()), 64'(exp[sel].size()));
        for (int i = 0; i < got[sel].size() && i < exp[sel].size(); i++)
            check(tag, 64'(got[sel][i]), 64'(exp[sel][i]));
    endtask

    task automatic clear(input int sel);
        got[sel].delete();
        exp[sel].delete();
        fd_cnt[sel] = 0;
    endtask

    task automatic check_idle(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_m_valid"}, 64'(m_valid[i]), 64'(0));
            check({tag, "_m_data"}, 64'(m_data[i]), 64'(0));
            check({tag, "_m_last"}, 64'(m_last[i]), 64'(0));
            check({tag, "_frame_done"}, 64'(frame_done[i]), 64'(0));
            check({tag, "_s_ready"}, 64'(s_ready[i]), 64'(1));
        end
    endtask

    task automatic check_ramp4(input string tag);
        logic [32:0] want [4];
        want = '{{1'b0, 32'd5}, {1'b0, 32'd7}, {1'b0, 32'd13}, {1'b1, 32'd15}};
        for (int i = 0; i < 4; i++)
            check(tag, 64'((i < got[0].size()) ? got[0][i] : 33'h0), 64'(want[i]));
        check({tag, "_frame_done"}, 64'(fd_cnt[0]), 64'(1));
    endtask

    initial begin
        logic [31:0] d0;
        int t0;
        total = 0; bad = 0; cyc = 0;
        fd_cnt[0] = 0; fd_cnt[1] = 0;
        for (int i = 0; i < 2; i++) begin
            s_valid[i] = 1'b0; s_data[i] = '0; m_ready[i] = 1'b1;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 4x4 ramp
        clear(0);
        run_frame(0, 0, 0, 16);
        drain_and_compare(0, "ramp4");
        check_ramp4("ramp4_const");

        // signed lanes
        clear(0);
        run_frame(0, 2, 0, 16);
        drain_and_compare(0, "signed4");
        check("signed4_word0", 64'((got[0].size() > 0) ? got[0][0][31:0] : 32'h0), 64'(32'h7F7F_0101));

        // 26x26 with 50% input gaps
        clear(1);
        run_frame(1, 1, 50, 676);
        drain_and_compare(1, "gaps26");
        check("gaps26_frame_done", 64'(fd_cnt[1]), 64'(1));

        // output stall of 10 cycles at the first result
        clear(1);
        m_ready[1] = 1'b0;
        fork
            run_frame(1, 1, 0, 676);
            begin
                int n;
                n = 0;
                while (!m_valid[1] && n < 3000) begin @(posedge clk); #1; n++; end
                check("stall_first_valid", 64'(m_valid[1]), 64'(1));
                d0 = m_data[1];
                repeat (10) begin
                    @(negedge clk);
                    check("stall_s_ready", 64'(s_ready[1]), 64'(0));
                    check("stall_m_valid", 64'(m_valid[1]), 64'(1));
                    check("stall_m_data", 64'(m_data[1]), 64'(d0));
                end
                @(posedge clk); #1;
                m_ready[1] = 1'b1;
            end
        join
        drain_and_compare(1, "stall26");

        // mid-frame reset: small at row 3 col 1, big at row 3 col 5
        clear(0); clear(1);
        run_frame(0, 1, 0, 13);
        run_frame(1, 1, 0, 83);
        drain_and_compare(0, "partial4");
        drain_and_compare(1, "partial26");
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("midreset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear(0); clear(1);
        run_frame(0, 0, 0, 16);
        drain_and_compare(0, "after_rst4");
        check_ramp4("after_rst4_const");
        run_frame(1, 1, 20, 676);
        drain_and_compare(1, "after_rst26");

        // back-to-back frames at full rate
        clear(0); clear(1);
        run_frame(0, 0, 0, 16);
        run_frame(0, 1, 0, 16);
        drain_and_compare(0, "b2b4");
        check("b2b4_frame_done", 64'(fd_cnt[0]), 64'(2));
        t0 = cyc;
        run_frame(1, 1, 0, 676);
        run_frame(1, 1, 0, 676);
        check("b2b26_cycles", 64'(cyc - t0), 64'(1352));
        drain_and_compare(1, "b2b26");
        check("b2b26_frame_done", 64'(fd_cnt[1]), 64'(2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mp_pool2x2_stream.md
Name: mp_pool2x2_stream

Overview:
- Streaming 2x2/stride-2 max-pool stage for the YOLOv2 feature pipeline.
- Consumes one raster-scan input feature map of IMG_W x IMG_H words. Each word is packed signed 8-bit channel lanes.
- Emits (IMG_W/2) x (IMG_H/2) pooled words.
- Uses one mp_bram instance (LOW_LATENCY, depth IMG_W/2) as a half-row line buffer holding the horizontal-pair maxima of even rows.

Parameters:
- DATA_WIDTH, 32, packed word width; must be LANES*LANE_WIDTH.
- LANE_WIDTH, 8, signed lane width.
- IMG_W, 26, input row length in words; must be even, >=2.
- IMG_H, 26, input rows per frame; must be even, >=2.

Ports:
- clka, input, 1, clock.
- rsta, input, 1, asynchronous active-low reset.
- s_valid, input, 1, input word valid.
- s_ready, output, 1, input word accepted when s_valid & s_ready.
- s_data, input, DATA_WIDTH, input pixel word, raster order.
- m_valid, output, 1, pooled word valid.
- m_ready, input, 1, downstream accept.
- m_data, output, DATA_WIDTH, pooled word.
- m_last, output, 1, high with the final pooled word of a frame.
- frame_done, output, 1, one-cycle pulse on the cycle the last pooled word is accepted.

Behaviour:
- Reset (rsta=0, async) clears the following:
  - col, row and state to ROW_EVEN;
  - the pair-hold register;
  - m_valid, m_data, m_last and frame_done to 0.
- Reset does not clear line-buffer contents. They are always rewritten before being read.
- Handshake and flow control:
  - s_ready = !(m_valid & !m_ready). This is combinational and depends on no s_* input.
  - m_* is a single output register. Its data is held stable while m_valid & !m_ready.
- Counters:
  - col counts 0..IMG_W-1 per accepted word.
  - row counts 0..IMG_H-1; it wraps to 0 after the last word of the frame.
  - Counter widths are clog2 of the bounds.
- State is ROW_EVEN when row[0]=0 and ROW_ODD otherwise. State flips at col wrap.
- Lane max: per-lane signed compare, result = larger lane value. Ties keep either value (identical bits).
- col even, any row: hold <= s_data.
- col odd, ROW_EVEN: hmax = lanemax(hold, s_data); BRAM write at addr col>>1 (ena=1, wea=1).
- Read issue, col even in ROW_ODD: also issue a BRAM read at addr col>>1 (ena=1, wea=0).
  - douta is valid the next cycle.
  - douta stays stable afterwards because ena is low until the next access, so input gaps are tolerated.
- Result, col odd in ROW_ODD:
  - m_data <= lanemax(lanemax(hold, s_data), douta); m_valid <= 1.
  - m_last <= (row==IMG_H-1 && col==IMG_W-1).
- The BRAM is never read and written in the same cycle. Tie regcea=1 and rsta=1 on the instance.
- Latency: a pooled word appears on m_* the cycle after the accepted second pixel of an odd-row pair.
- m_valid drops after a handshake unless a new result loads in the same cycle. Back-to-back output at one word per 2 input beats is required.
- Output stall: s_ready falls while m_valid & !m_ready.
  - It is never needed during even rows, but the rule is applied uniformly.
  - No input word is lost or duplicated.
- Frame boundary: the next frame's first word may be accepted the cycle after the last input word. It needs no idle gap.
- Mid-frame reset aborts the frame. The next accepted word is treated as row 0, col 0.

Decomposition:
- Shared package mp_pkg holds:
  - LANES = DATA_WIDTH/LANE_WIDTH;
  - function lane_max(a,b) (packed per-lane signed max);
  - the state encoding ROW_EVEN=1'b0, ROW_ODD=1'b1.
- Sub-module: the existing mp_bram, instantiated with RAM_WIDTH=DATA_WIDTH, RAM_DEPTH=IMG_W/2, RAM_PERFORMANCE="LOW_LATENCY".
- The counter/control logic stays in this module.

Test Plan:
- 4x4 frame, continuous valid, m_ready=1, lane0 = raster index 0..15, other lanes 0 -> outputs lane0 = 5, 7, 13, 15; m_last only on 15; one frame_done pulse.
- Signed lanes: pair words 0x80_7F_FF_01 and 0x01_80_00_FF, with row below 0xFE_00_01_80 and 0x7F_81_80_00 -> output 0x7F_7F_01_01.
- Random s_valid gaps (50%) on a 26x26 frame -> 169 outputs matching the reference model; douta held correctly across gaps.
- m_ready held low 10 cycles after the first output -> s_ready=0 during the stall, m_data stable, no loss; afterwards 169 outputs total.
- Reset asserted at row 3, col 5; then a fresh 4x4 frame -> outputs exactly as in test 1, no stale line-buffer data.
- Two frames back-to-back without gap -> 2x expected outputs; m_last and frame_done once per frame.
